// File: rtl/acc_ctrl.sv
// Accumulator controller closing the loop around an external combinational ALU.
// Latency: accept at edge N, result valid after edge N+1; one instruction per 3 cycles at best.
// Backpressure: result held stable until out_ready; no new instruction accepted until then.
module acc_ctrl #(
  parameter int                 DATA_W   = 4,
  parameter int                 CNT_W    = 8,
  parameter logic [DATA_W-1:0]  ACC_INIT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_operand,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_acc,
  output logic              out_err,
  output logic [CNT_W-1:0]  op_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] SEL_DIV   = 3'b011;
  localparam logic [2:0] CTL_LOAD  = 3'b000;
  localparam logic [2:0] CTL_CLEAR = 3'b001;
  localparam logic [2:0] CTL_READ  = 3'b010;

  logic [1:0]        state;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] operand_q;
  logic [DATA_W-1:0] acc;
  logic              err;
  logic [DATA_W-1:0] acc_nxt;
  logic              err_nxt;

  // The ALU always sees the accumulator and the latched instruction; only EXEC captures its result.
  assign in_ready = (state == S_IDLE);
  assign alu_a    = acc;
  assign alu_b    = operand_q;
  assign alu_sel  = {1'b0, op_q[2:0]};
  assign out_acc  = acc;
  assign out_err  = err;

  // Decode the latched instruction into the accumulator update applied at the end of EXEC.
  always_comb begin
    acc_nxt = acc;
    err_nxt = 1'b0;
    if (!op_q[3]) begin
      if ((op_q[2:0] == SEL_DIV) && (operand_q == '0)) begin
        err_nxt = 1'b1;
      end else begin
        acc_nxt = alu_y;
      end
    end else begin
      case (op_q[2:0])
        CTL_LOAD:  acc_nxt = operand_q;
        CTL_CLEAR: acc_nxt = ACC_INIT;
        CTL_READ:  acc_nxt = acc;
        default:   err_nxt = 1'b1;
      endcase
    end
  end

  // Three-state sequencer: accept, execute for one cycle, then hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      operand_q <= '0;
      acc       <= ACC_INIT;
      err       <= 1'b0;
      out_valid <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q      <= in_op;
            operand_q <= in_operand;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          acc       <= acc_nxt;
          err       <= err_nxt;
          out_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // Errored instructions still complete a handshake and are counted.
            if (op_count != {CNT_W{1'b1}}) begin
              op_count <= op_count + 1'b1;
            end
            state <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_ctrl.sv
// Bench for acc_ctrl: behavioural 4-bit ALU in the loop, reference accumulator model,
// expected results queued at accept time and compared when the result handshake appears.
module tb_acc_ctrl;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [DATA_W-1:0] in_operand;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_sel;
  logic [DATA_W-1:0] alu_y;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_acc;
  logic              out_err;
  logic [CNT_W-1:0]  op_count;

  typedef struct packed {
    logic [DATA_W-1:0] acc;
    logic              err;
  } exp_t;

  exp_t exp_q[$];
  logic [DATA_W-1:0] m_acc;
  int unsigned       m_cnt;
  int                n_checks = 0;
  int                n_pass   = 0;

  always #5 clk = ~clk;

  acc_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .ACC_INIT(4'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_operand(in_operand),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_err(out_err),
    .op_count(op_count)
  );

  // Bench ALU: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 LT.
  function automatic logic [DATA_W-1:0] alu_f(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [3:0] sel);
    logic [7:0] p;
    case (sel[2:0])
      3'd0: alu_f = a + b;
      3'd1: alu_f = a - b;
      3'd2: begin p = a * b; alu_f = p[DATA_W-1:0]; end
      3'd3: alu_f = (b == 0) ? '0 : a / b;
      3'd4: alu_f = a & b;
      3'd5: alu_f = a | b;
      3'd6: alu_f = a ^ b;
      default: alu_f = (a < b) ? 4'd1 : 4'd0;
    endcase
  endfunction

  assign alu_y = alu_f(alu_a, alu_b, alu_sel);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference: expected accumulator/error for one instruction against the current model state.
  function automatic exp_t ref_op(input logic [3:0] op, input logic [DATA_W-1:0] opnd,
                                  input logic [DATA_W-1:0] acc);
    exp_t e;
    e.acc = acc;
    e.err = 1'b0;
    if (!op[3]) begin
      if (op[2:0] == 3'd3 && opnd == 0) e.err = 1'b1;
      else e.acc = alu_f(acc, opnd, op);
    end else if (op == 4'b1000) e.acc = opnd;
    else if (op == 4'b1001) e.acc = '0;
    else if (op == 4'b1010) e.acc = acc;
    else e.err = 1'b1;
    return e;
  endfunction

  // One full instruction: accept, check EXEC drive, check result, optional backpressure, handshake.
  task automatic do_op(input logic [3:0] op, input logic [DATA_W-1:0] opnd, input int bp);
    exp_t e;
    exp_t got;
    int k;
    logic [DATA_W-1:0] a_prev;
    logic [DATA_W-1:0] held;
    k = 0;
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    check("idle_ready", {31'd0, in_ready}, 32'd1);
    in_valid   = 1'b1;
    in_op      = op;
    in_operand = opnd;
    a_prev = m_acc;
    e = ref_op(op, opnd, m_acc);
    exp_q.push_back(e);
    m_acc = e.acc;
    @(negedge clk);
    in_valid   = 1'b0;
    in_op      = 4'($urandom);
    in_operand = 4'($urandom);
    check("exec_ready", {31'd0, in_ready}, 32'd0);
    check("exec_alu_a", {28'd0, alu_a}, {28'd0, a_prev});
    check("exec_alu_b", {28'd0, alu_b}, {28'd0, opnd});
    check("exec_alu_sel", {28'd0, alu_sel}, {29'd0, op[2:0]});
    k = 0;
    while (!out_valid && k < 10) begin @(negedge clk); k++; end
    check("latency", k, 32'd1);
    if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      check("out_acc", {28'd0, out_acc}, {28'd0, got.acc});
      check("out_err", {31'd0, out_err}, {31'd0, got.err});
    end
    held = out_acc;
    for (int i = 0; i < bp; i++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_acc", {28'd0, out_acc}, {28'd0, held});
      check("bp_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (m_cnt != 255) m_cnt++;
    check("op_count", {24'd0, op_count}, m_cnt);
    check("post_valid", {31'd0, out_valid}, 32'd0);
    check("post_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_operand = '0; out_ready = 1'b0;
    m_acc = '0; m_cnt = 0;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count", {24'd0, op_count}, 32'd0);
    check("rst_alu_a", {28'd0, alu_a}, 32'd0);
    check("rst_alu_sel", {28'd0, alu_sel}, 32'd0);
    check("rst_err", {31'd0, out_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of EXEC aborts silently.
    do_op(4'b1000, 4'd5, 0);
    in_valid = 1'b1; in_op = 4'b1000; in_operand = 4'd7;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_acc", {28'd0, alu_a}, 32'd0);
    check("abort_count", {24'd0, op_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_acc = '0; m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_result", {31'd0, out_valid}, 32'd0);
      check("abort_ready", {31'd0, in_ready}, 32'd1);
    end

    // LOAD 5, ADD 3 -> 8
    do_op(4'b1000, 4'd5, 0);
    do_op(4'b0000, 4'd3, 0);
    check("add_const", {28'd0, m_acc}, 32'd8);
    // LOAD 9, DIV 0 -> err, DIV 2 -> 4
    do_op(4'b1000, 4'd9, 0);
    do_op(4'b0011, 4'd0, 0);
    do_op(4'b0011, 4'd2, 0);
    // Wrap and truncating multiply
    do_op(4'b1000, 4'd15, 0);
    do_op(4'b0000, 4'd1, 0);
    do_op(4'b1000, 4'd6, 0);
    do_op(4'b0010, 4'd3, 0);
    check("mul_const", {28'd0, m_acc}, 32'd2);
    // Backpressure
    do_op(4'b0000, 4'd2, 5);
    // Illegal op, READ, CLEAR
    do_op(4'b1100, 4'd9, 0);
    do_op(4'b1010, 4'd3, 1);
    do_op(4'b1001, 4'd7, 0);
    // Many random instructions to reach counter saturation
    for (int i = 0; i < 300; i++) begin
      do_op(4'($urandom_range(0, 15)), 4'($urandom), (i % 37 == 0) ? 2 : 0);
    end
    check("sat_count", {24'd0, op_count}, 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
